// File: rtl/tdc_eventfifo_pkg.sv
// Shared definitions for the TDC event FIFO: CSR word offsets, register
// bit-field positions and the FIFO entry width.
package tdc_eventfifo_pkg;

   typedef enum logic [2:0] {
      REG_STATUS   = 3'd0,
      REG_HEAD_LO  = 3'd1,
      REG_HEAD_HI  = 3'd2,
      REG_POP      = 3'd3,
      REG_CTRL     = 3'd4,
      REG_OVERFLOW = 3'd5
   } csr_reg_e;

   localparam int unsigned STATUS_EMPTY_BIT = 0;
   localparam int unsigned STATUS_FULL_BIT  = 1;
   localparam int unsigned STATUS_LEVEL_LSB = 8;
   localparam int unsigned HEADHI_POL_BIT   = 16;
   localparam int unsigned HEADHI_CH_LSB    = 24;
   localparam int unsigned CTRL_IRQEN_BIT   = 0;

   localparam int unsigned CH_IDX_W = 3;
   localparam int unsigned OVF_W    = 16;

   // Entry layout is {channel, polarity, timestamp}.
   function automatic int unsigned entry_width(input int unsigned ts_width);
      return ts_width + CH_IDX_W + 1;
   endfunction

endpackage

// File: rtl/tdc_eventfifo_ram.sv
// Simple dual-port storage for the event FIFO: synchronous write,
// asynchronous read, no reset on the array.
module tdc_eventfifo_ram #(
   parameter int unsigned g_ADDR_W = 4,
   parameter int unsigned g_DATA_W = 42
) (
   input  logic                i_clk,
   input  logic                i_we,
   input  logic [g_ADDR_W-1:0] i_waddr,
   input  logic [g_DATA_W-1:0] i_wdata,
   input  logic [g_ADDR_W-1:0] i_raddr,
   output logic [g_DATA_W-1:0] o_rdata
);

   logic [g_DATA_W-1:0] r_mem [2**g_ADDR_W];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tdc_eventfifo.sv
// TDC event capture: per-channel pending registers, round-robin arbitration
// into a synchronous FIFO, and a CSR page exposing head, status and drops.
module tdc_eventfifo
   import tdc_eventfifo_pkg::*;
#(
   parameter logic [3:0]  csr_addr        = 4'h2,
   parameter int unsigned g_CHANNEL_COUNT = 2,
   parameter int unsigned g_TS_WIDTH      = 38,
   parameter int unsigned g_DEPTH_LOG2    = 4
) (
   input  logic                                  sys_clk,
   input  logic                                  rst_n_i,
   input  logic [g_CHANNEL_COUNT-1:0]            detect_i,
   input  logic [g_CHANNEL_COUNT-1:0]            polarity_i,
   input  logic [g_CHANNEL_COUNT*g_TS_WIDTH-1:0] ts_i,
   input  logic [13:0]                           csr_a,
   input  logic                                  csr_we,
   input  logic [31:0]                           csr_di,
   output logic [31:0]                           csr_do,
   output logic                                  irq
);

   localparam int unsigned EW = entry_width(g_TS_WIDTH);
   localparam int unsigned PW = g_DEPTH_LOG2 + 1;

   logic [PW-1:0]              r_wptr, r_rptr, w_level;
   logic                       w_empty, w_full;
   logic [g_CHANNEL_COUNT-1:0] r_pend, r_pend_pol, w_gnt_oh, w_drop;
   logic [g_TS_WIDTH-1:0]      r_pend_ts [g_CHANNEL_COUNT];
   logic [CH_IDX_W-1:0]        r_rr, w_gnt_idx;
   logic                       w_gnt_vld, w_gnt_pol;
   logic [g_TS_WIDTH-1:0]      w_gnt_ts;
   logic [EW-1:0]              w_wdata, w_rdata;
   logic                       w_sel, w_wr, w_pop;
   csr_reg_e                   w_off;
   logic [3:0]                 w_drop_cnt;
   logic [OVF_W:0]             w_ovf_sum;
   logic [OVF_W-1:0]           r_ovf;
   logic                       r_irq_en, r_irq;
   logic [31:0]                r_csr_do, w_rd_mux, w_status, w_head_hi;
   logic [g_TS_WIDTH-1:0]      w_head_ts;
   logic                       w_head_pol;
   logic [CH_IDX_W-1:0]        w_head_ch;
   logic                       w_unused;

   assign w_sel    = (csr_a[13:10] == csr_addr);
   assign w_off    = csr_reg_e'(csr_a[2:0]);
   assign w_wr     = w_sel & csr_we;
   assign w_pop    = w_wr && (w_off == REG_POP) && !w_empty;
   assign w_unused = ^{csr_di[31:1], csr_a[9:3]};

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                    (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
   assign w_level = r_wptr - r_rptr;

   // Round-robin: offset i=1 is the channel after the last grant.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_gnt_pol = 1'b0;
      w_gnt_ts  = '0;
      w_gnt_oh  = '0;
      for (int unsigned i = 1; i <= g_CHANNEL_COUNT; i++) begin
         for (int unsigned c = 0; c < g_CHANNEL_COUNT; c++) begin
            if (!w_gnt_vld && !w_full && r_pend[c] &&
                (c == (32'(r_rr) + i) % g_CHANNEL_COUNT)) begin
               w_gnt_vld   = 1'b1;
               w_gnt_idx   = CH_IDX_W'(c);
               w_gnt_pol   = r_pend_pol[c];
               w_gnt_ts    = r_pend_ts[c];
               w_gnt_oh[c] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_drop     = '0;
      w_drop_cnt = '0;
      for (int unsigned c = 0; c < g_CHANNEL_COUNT; c++) begin
         w_drop[c]  = detect_i[c] & r_pend[c] & ~w_gnt_oh[c];
         w_drop_cnt = w_drop_cnt + 4'(w_drop[c]);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n_i) begin
         r_pend <= '0;
      end else begin
         for (int unsigned c = 0; c < g_CHANNEL_COUNT; c++) begin
            if (detect_i[c]) begin
               r_pend[c] <= 1'b1;
            end else if (w_gnt_oh[c]) begin
               r_pend[c] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      for (int unsigned c = 0; c < g_CHANNEL_COUNT; c++) begin
         if (detect_i[c] && !w_drop[c]) begin
            r_pend_pol[c] <= polarity_i[c];
            r_pend_ts[c]  <= ts_i[c*g_TS_WIDTH +: g_TS_WIDTH];
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_rr   <= '0;
      end else begin
         if (w_gnt_vld) begin
            r_wptr <= r_wptr + 1'b1;
            r_rr   <= w_gnt_idx;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   assign w_wdata = {w_gnt_idx, w_gnt_pol, w_gnt_ts};

   tdc_eventfifo_ram #(
      .g_ADDR_W (g_DEPTH_LOG2),
      .g_DATA_W (EW)
   ) u_ram (
      .i_clk   (sys_clk),
      .i_we    (w_gnt_vld),
      .i_waddr (r_wptr[g_DEPTH_LOG2-1:0]),
      .i_wdata (w_wdata),
      .i_raddr (r_rptr[g_DEPTH_LOG2-1:0]),
      .o_rdata (w_rdata)
   );

   assign w_head_ts  = w_rdata[g_TS_WIDTH-1:0];
   assign w_head_pol = w_rdata[g_TS_WIDTH];
   assign w_head_ch  = w_rdata[EW-1 -: CH_IDX_W];

   // A clear and a same-cycle drop leave the counter at the new drop count.
   always_comb begin
      w_ovf_sum = ((w_wr && (w_off == REG_OVERFLOW)) ? '0 : {1'b0, r_ovf})
                  + (OVF_W+1)'(w_drop_cnt);
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n_i) begin
         r_ovf <= '0;
      end else begin
         r_ovf <= w_ovf_sum[OVF_W] ? '1 : w_ovf_sum[OVF_W-1:0];
      end
   end

   always_comb begin
      w_status                             = '0;
      w_status[STATUS_EMPTY_BIT]           = w_empty;
      w_status[STATUS_FULL_BIT]            = w_full;
      w_status[STATUS_LEVEL_LSB +: PW]     = w_level;
      w_head_hi                            = '0;
      w_head_hi[7:0]                       = 8'(w_head_ts >> 32);
      w_head_hi[HEADHI_POL_BIT]            = w_head_pol;
      w_head_hi[HEADHI_CH_LSB +: CH_IDX_W] = w_head_ch;
      case (w_off)
         REG_STATUS:   w_rd_mux = w_status;
         REG_HEAD_LO:  w_rd_mux = w_head_ts[31:0];
         REG_HEAD_HI:  w_rd_mux = w_head_hi;
         REG_CTRL:     w_rd_mux = {31'b0, r_irq_en};
         REG_OVERFLOW: w_rd_mux = {{(32-OVF_W){1'b0}}, r_ovf};
         default:      w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n_i) begin
         r_irq_en <= 1'b0;
         r_csr_do <= '0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr && (w_off == REG_CTRL)) begin
            r_irq_en <= csr_di[CTRL_IRQEN_BIT];
         end
         r_csr_do <= w_sel ? w_rd_mux : '0;
         r_irq    <= r_irq_en & ~w_empty;
      end
   end

   assign csr_do = r_csr_do;
   assign irq    = r_irq;

endmodule
